mbist_data_gen: RTL

Parametrised MBIST data-background generator that replaces the fixed 8-bit generator. It produces the write data, and a one-cycle-delayed expected-read copy, for the MBIST controller on each enabled cycle. Supported patterns are solid, column stripe, checkerboard, row stripe, address-as-data, walking-1/0 and LFSR pseudo-random, each with per-march-element polarity inversion. It sits between the MBIST controller FSM (source of PAT_SEL/INV/ADDR/DATA_EN/START) and the SRAM write port and comparator.

---
 rtl/mbist_pkg.sv | 26 ++
 rtl/mbist_lfsr.sv | 41 ++++
 rtl/mbist_data_gen.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mbist_pkg.sv
// Shared MBIST constants: pattern codes and default LFSR taps.
// Imported by the data generator and the LFSR.
package mbist_pkg;

  localparam logic [2:0] PAT_SOLID  = 3'd0;
  localparam logic [2:0] PAT_COLSTR = 3'd1;
  localparam logic [2:0] PAT_CHKB   = 3'd2;
  localparam logic [2:0] PAT_ROWSTR = 3'd3;
  localparam logic [2:0] PAT_ADDR   = 3'd4;
  localparam logic [2:0] PAT_WALK   = 3'd5;
  localparam logic [2:0] PAT_LFSR   = 3'd6;
  localparam logic [2:0] PAT_RSVD   = 3'd7;

  localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8;
  localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_B400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'hA300_0000;

  function automatic logic [31:0] default_taps(input int w);
    logic [31:0] t;
    t = LFSR_TAPS_8;
    if (w == 16) t = LFSR_TAPS_16;
    if (w == 32) t = LFSR_TAPS_32;
    return t;
  endfunction

endpackage

// File: rtl/mbist_lfsr.sv
// Galois LFSR with synchronous seed reload; zero seed becomes 1.
// Shared by the data and address generators.
module mbist_lfsr
  import mbist_pkg::*;
#(
  parameter int              DATA_W = 8,
  parameter logic [DATA_W-1:0] TAPS =
    DATA_W'(default_taps(DATA_W)),
  parameter logic [DATA_W-1:0] SEED = DATA_W'(8'hA5)
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              load,
  input  logic              step,
  output logic [DATA_W-1:0] state
);

  localparam logic [DATA_W-1:0] SEED_EFF =
    (SEED == '0) ? DATA_W'(1) : SEED;

  logic [DATA_W-1:0] state_q;
  logic [DATA_W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = SEED_EFF;
    end else if (step) begin
      state_d = state_q >> 1;
      if (state_q[0]) state_d = state_d ^ TAPS;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state_q <= SEED_EFF;
    else         state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/mbist_data_gen.sv
// MBIST data-background generator: write word plus a
// one-cycle-delayed expected copy for the read comparator.
module mbist_data_gen
  import mbist_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter int              ADDR_W    = 8,
  parameter logic [DATA_W-1:0] LFSR_TAPS =
    DATA_W'(default_taps(DATA_W)),
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(8'hA5)
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              START,
  input  logic              DATA_EN,
  input  logic [2:0]        PAT_SEL,
  input  logic              INV,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] WDATA,
  output logic              DATA_VLD,
  output logic [DATA_W-1:0] EXP_DATA,
  output logic              EXP_VLD,
  output logic              PAT_ERR
);

  localparam int WALK_W = $clog2(DATA_W);
  localparam logic [63:0] STRIPE64 = {32{2'b01}};
  localparam logic [DATA_W-1:0] STRIPE = STRIPE64[DATA_W-1:0];
  localparam logic [WALK_W-1:0] WALK_LAST = WALK_W'(DATA_W-1);

  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic              vld_q, vld_d;
  logic              expvld_q, expvld_d;
  logic              err_q, err_d;
  logic [WALK_W-1:0] walk_q, walk_d;
  logic [DATA_W-1:0] lfsr_state;
  logic              lfsr_step;
  logic [DATA_W-1:0] addr_data;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] row;
  logic [DATA_W-1:0] one_hot;

  generate
    if (ADDR_W >= DATA_W) begin : g_addr_trunc
      assign addr_data = ADDR[DATA_W-1:0];
    end else begin : g_addr_ext
      assign addr_data = {{(DATA_W-ADDR_W){1'b0}}, ADDR};
    end
  endgenerate

  assign mask    = {DATA_W{INV}};
  assign row     = {DATA_W{ADDR[0]}};
  assign one_hot = DATA_W'(1) << walk_q;

  mbist_lfsr #(
    .DATA_W (DATA_W),
    .TAPS   (LFSR_TAPS),
    .SEED   (LFSR_SEED)
  ) u_lfsr (
    .CLK    (CLK),
    .nRESET (nRESET),
    .load   (START),
    .step   (lfsr_step),
    .state  (lfsr_state)
  );

  always_comb begin
    wdata_d   = wdata_q;
    vld_d     = 1'b0;
    err_d     = err_q;
    walk_d    = walk_q;
    lfsr_step = 1'b0;
    expvld_d  = vld_q;
    exp_d     = vld_q ? wdata_q : exp_q;
    if (START) begin
      walk_d = '0;
      err_d  = 1'b0;
    end else if (DATA_EN) begin
      vld_d = 1'b1;
      unique case (1'b1)
        (PAT_SEL == PAT_SOLID):  wdata_d = mask;
        (PAT_SEL == PAT_COLSTR): wdata_d = STRIPE ^ mask;
        (PAT_SEL == PAT_CHKB):   wdata_d = STRIPE ^ row ^ mask;
        (PAT_SEL == PAT_ROWSTR): wdata_d = row ^ mask;
        (PAT_SEL == PAT_ADDR):   wdata_d = addr_data ^ mask;
        (PAT_SEL == PAT_WALK): begin
          wdata_d = one_hot ^ mask;
          walk_d  = (walk_q == WALK_LAST) ? '0 : walk_q + 1'b1;
        end
        (PAT_SEL == PAT_LFSR): begin
          wdata_d   = lfsr_state ^ mask;
          lfsr_step = 1'b1;
        end
        default: begin
          wdata_d = '0;
          err_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wdata_q  <= '0;
      vld_q    <= 1'b0;
      exp_q    <= '0;
      expvld_q <= 1'b0;
      err_q    <= 1'b0;
      walk_q   <= '0;
    end else begin
      wdata_q  <= wdata_d;
      vld_q    <= vld_d;
      exp_q    <= exp_d;
      expvld_q <= expvld_d;
      err_q    <= err_d;
      walk_q   <= walk_d;
    end
  end

  assign WDATA    = wdata_q;
  assign DATA_VLD = vld_q;
  assign EXP_DATA = exp_q;
  assign EXP_VLD  = expvld_q;
  assign PAT_ERR  = err_q;

endmodule
